// File: rtl/operand_issue_ctrl_if.sv
// Bundle of the control-side and datapath-side signals of operand_issue_ctrl.
// The master modport is the driver of operands/requests (control, memory ready).
// The slave modport is the sequencer itself.
interface operand_issue_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 12
);
  logic          put_en;
  logic [DW-1:0] put_value;
  logic          op_en;
  logic [1:0]    op_kind;
  logic [3:0]    alu_op_in;
  logic          mem_ready;
  logic          err_clr;
  logic [3:0]    rd_addrA;
  logic [3:0]    rd_addrB;
  logic [3:0]    wr_addr;
  logic [3:0]    ALUOp;
  logic          reg_wr_en;
  logic [1:0]    wb_sel;
  logic          mem_rd_en;
  logic          mem_wr_en;
  logic          absjump_en;
  logic [AW-1:0] target;
  logic          pc_stall;
  logic [1:0]    slot_cnt;
  logic          err;

  modport master (
    output put_en, put_value, op_en, op_kind, alu_op_in, mem_ready, err_clr,
    input  rd_addrA, rd_addrB, wr_addr, ALUOp, reg_wr_en, wb_sel,
           mem_rd_en, mem_wr_en, absjump_en, target, pc_stall, slot_cnt, err
  );

  modport slave (
    input  put_en, put_value, op_en, op_kind, alu_op_in, mem_ready, err_clr,
    output rd_addrA, rd_addrB, wr_addr, ALUOp, reg_wr_en, wb_sel,
           mem_rd_en, mem_wr_en, absjump_en, target, pc_stall, slot_cnt, err
  );
endinterface

// File: rtl/operand_issue_ctrl.sv
// operand_issue_ctrl: collects up to three PUT operands (r0/r1/r2) and, on an
// OP request, sequences one ALU / LOAD / STORE / JUMP operation, holding
// pc_stall while it is in flight. All outputs come straight from registers.
// Optional feature: define ISSUE_MEM_TIMEOUT_EN to abort a memory access that
// sees no mem_ready for TIMEOUT cycles (sets err, skips write-back).
module operand_issue_ctrl #(
  parameter int DW      = 8,
  parameter int AW      = 12,
  parameter int TIMEOUT = 16
) (
  input logic                 clk,
  input logic                 reset,
  operand_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_COLLECT  = 2'd0,
    S_EXEC     = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_WB       = 2'd3
  } state_t;

  localparam logic [1:0] K_ALU   = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;
  localparam logic [1:0] K_JUMP  = 2'd3;

  // r0 only contributes its address nibble and the upper jump-target bits
  localparam int S0W = ((AW - DW) > 4) ? (AW - DW) : 4;

  state_t         r_state, w_state_nxt, w_mem_state;
  logic [S0W-1:0] r_slot0;
  logic [DW-1:0]  r_slot1;
  logic [3:0]     r_slot2;
  logic [1:0]     r_slot_cnt, r_kind, w_kind_nxt, w_need;
  logic           w_accept, w_op_drop, w_put_ok, w_err_set, w_timeout;
  logic           w_rwe, w_mrd, w_mwr, w_aj, w_stall;
  logic [3:0]     r_rd_a, r_rd_b, r_wr, r_aluop;
  logic [1:0]     r_wb_sel;
  logic [AW-1:0]  r_target;
  logic           r_rwe, r_mrd, r_mwr, r_aj, r_stall, r_err;

`ifdef ISSUE_MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_to_cnt;

  // Cycles spent waiting for mem_ready since the memory op was accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (w_accept) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_EXEC) || (r_state == S_MEM_WAIT)) begin
      r_to_cnt <= r_to_cnt + TW'(1'b1);
    end
  end

  assign w_timeout = ((r_state == S_EXEC) || (r_state == S_MEM_WAIT)) &&
                     ((r_kind == K_LOAD) || (r_kind == K_STORE)) &&
                     !bus.mem_ready && (r_to_cnt == TW'(TIMEOUT - 1));
`else
  // Without the watchdog the memory wait is unbounded and TIMEOUT has no role
  if (TIMEOUT < 1) begin : g_timeout_unused
  end
  assign w_timeout = 1'b0;
`endif

  // Where a pending memory access goes next, given mem_ready and the watchdog
  always_comb begin
    if (bus.mem_ready) begin
      if (r_kind == K_LOAD) begin
        w_mem_state = S_WB;
      end else begin
        w_mem_state = S_COLLECT;
      end
    end else if (w_timeout) begin
      w_mem_state = S_COLLECT;
    end else begin
      w_mem_state = S_MEM_WAIT;
    end
  end

  // Next-state, request acceptance and protocol-error detection
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_op_drop   = 1'b0;
    w_put_ok    = 1'b0;
    w_err_set   = 1'b0;
    w_need      = (bus.op_kind == K_ALU) ? 2'd3 : 2'd2;
    case (r_state)
      S_COLLECT: begin
        if (bus.op_en) begin
          if (r_slot_cnt >= w_need) begin
            w_accept    = 1'b1;
            w_state_nxt = S_EXEC;
            w_err_set   = bus.put_en;
          end else begin
            w_op_drop = 1'b1;
            w_err_set = 1'b1;
          end
        end else if (bus.put_en) begin
          if (r_slot_cnt == 2'd3) begin
            w_err_set = 1'b1;
          end else begin
            w_put_ok = 1'b1;
          end
        end else begin
          w_state_nxt = S_COLLECT;
        end
      end
      S_EXEC: begin
        w_err_set = bus.op_en | bus.put_en | w_timeout;
        if ((r_kind == K_LOAD) || (r_kind == K_STORE)) begin
          w_state_nxt = w_mem_state;
        end else begin
          w_state_nxt = S_COLLECT;
        end
      end
      S_MEM_WAIT: begin
        w_err_set   = bus.op_en | bus.put_en | w_timeout;
        w_state_nxt = w_mem_state;
      end
      S_WB: begin
        w_err_set   = bus.op_en | bus.put_en;
        w_state_nxt = S_COLLECT;
      end
      default: begin
        w_state_nxt = S_COLLECT;
      end
    endcase
  end

  assign w_kind_nxt = w_accept ? bus.op_kind : r_kind;

  // Strobe values for the state being entered, so they appear registered in it
  always_comb begin
    w_rwe   = 1'b0;
    w_mrd   = 1'b0;
    w_mwr   = 1'b0;
    w_aj    = 1'b0;
    w_stall = 1'b0;
    case (w_state_nxt)
      S_EXEC: begin
        w_stall = 1'b1;
        case (w_kind_nxt)
          K_ALU:   w_rwe = 1'b1;
          K_LOAD:  w_mrd = 1'b1;
          K_STORE: w_mwr = 1'b1;
          K_JUMP:  w_aj  = 1'b1;
          default: w_aj  = 1'b0;
        endcase
      end
      S_MEM_WAIT: begin
        w_stall = 1'b1;
        if (r_kind == K_LOAD) begin
          w_mrd = 1'b1;
        end else begin
          w_mwr = 1'b1;
        end
      end
      S_WB: begin
        w_stall = 1'b1;
        w_rwe   = 1'b1;
      end
      default: begin
        w_stall = 1'b0;
      end
    endcase
  end

  // State, operand slots, latched operation fields and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_COLLECT;
      r_slot0    <= '0;
      r_slot1    <= '0;
      r_slot2    <= 4'd0;
      r_slot_cnt <= 2'd0;
      r_kind     <= K_ALU;
      r_rd_a     <= 4'd0;
      r_rd_b     <= 4'd0;
      r_wr       <= 4'd0;
      r_aluop    <= 4'd0;
      r_wb_sel   <= 2'd0;
      r_target   <= '0;
      r_rwe      <= 1'b0;
      r_mrd      <= 1'b0;
      r_mwr      <= 1'b0;
      r_aj       <= 1'b0;
      r_stall    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept || w_op_drop) begin
        r_slot0    <= '0;
        r_slot1    <= '0;
        r_slot2    <= 4'd0;
        r_slot_cnt <= 2'd0;
      end else if (w_put_ok) begin
        case (r_slot_cnt)
          2'd0:    r_slot0 <= bus.put_value[S0W-1:0];
          2'd1:    r_slot1 <= bus.put_value;
          2'd2:    r_slot2 <= bus.put_value[3:0];
          default: r_slot2 <= r_slot2;
        endcase
        r_slot_cnt <= r_slot_cnt + 2'd1;
      end
      if (w_accept) begin
        r_kind  <= bus.op_kind;
        r_rd_a  <= r_slot1[3:0];
        r_rd_b  <= r_slot2;
        r_wr    <= r_slot0[3:0];
        r_aluop <= bus.alu_op_in;
        if (bus.op_kind == K_ALU) begin
          r_wb_sel <= 2'd0;
        end
        if (bus.op_kind == K_JUMP) begin
          r_target <= {r_slot0[AW-DW-1:0], r_slot1};
        end
      end
      if (w_state_nxt == S_WB) begin
        r_wb_sel <= 2'd1;
      end
      r_rwe   <= w_rwe;
      r_mrd   <= w_mrd;
      r_mwr   <= w_mwr;
      r_aj    <= w_aj;
      r_stall <= w_stall;
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (bus.err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.rd_addrA   = r_rd_a;
  assign bus.rd_addrB   = r_rd_b;
  assign bus.wr_addr    = r_wr;
  assign bus.ALUOp      = r_aluop;
  assign bus.reg_wr_en  = r_rwe;
  assign bus.wb_sel     = r_wb_sel;
  assign bus.mem_rd_en  = r_mrd;
  assign bus.mem_wr_en  = r_mwr;
  assign bus.absjump_en = r_aj;
  assign bus.target     = r_target;
  assign bus.pc_stall   = r_stall;
  assign bus.slot_cnt   = r_slot_cnt;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_operand_issue_ctrl.sv
// Directed bench for operand_issue_ctrl. Expected output vectors come from a
// small bench-side model of the held fields; each is queued when the stimulus
// is driven and popped/compared half a clock after the edge that produces it.
module tb_operand_issue_ctrl;

  localparam logic [1:0] K_ALU = 2'd0, K_LOAD = 2'd1, K_STORE = 2'd2, K_JUMP = 2'd3;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  operand_issue_ctrl_if #(.DW(8), .AW(12)) bus ();

  operand_issue_ctrl #(.DW(8), .AW(12), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [37:0] w_obs;
  assign w_obs = {bus.rd_addrA, bus.rd_addrB, bus.wr_addr, bus.ALUOp, bus.reg_wr_en,
                  bus.wb_sel, bus.mem_rd_en, bus.mem_wr_en, bus.absjump_en,
                  bus.target, bus.pc_stall, bus.slot_cnt, bus.err};

  // bench model of the held (non-strobe) outputs
  logic [3:0]  m_a, m_b, m_w, m_op;
  logic [1:0]  m_wbs, m_cnt;
  logic [11:0] m_tgt;
  logic        m_err;

  logic [37:0] sb_q[$];
  string       tag_q[$];

  function automatic logic [37:0] mexp(input logic rwe, input logic mrd, input logic mwr,
                                       input logic aj, input logic st);
    return {m_a, m_b, m_w, m_op, rwe, m_wbs, mrd, mwr, aj, m_tgt, st, m_cnt, m_err};
  endfunction

  task automatic compare(input string tag, input logic [37:0] exp);
    checks++;
    assert (w_obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, w_obs, exp);
    end
  endtask

  task automatic drive(input logic pe, input logic [7:0] pv, input logic oe,
                       input logic [1:0] k, input logic [3:0] ao, input logic mr,
                       input logic ec);
    bus.put_en    = pe;
    bus.put_value = pv;
    bus.op_en     = oe;
    bus.op_kind   = k;
    bus.alu_op_in = ao;
    bus.mem_ready = mr;
    bus.err_clr   = ec;
  endtask

  // queue expectation for the next edge, advance one cycle, pop and compare
  task automatic cycle(input string tag, input logic rwe, input logic mrd,
                       input logic mwr, input logic aj, input logic st);
    sb_q.push_back(mexp(rwe, mrd, mwr, aj, st));
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    compare(tag_q.pop_front(), sb_q.pop_front());
  endtask

  task automatic put(input string tag, input logic [7:0] v);
    drive(1'b1, v, 1'b0, K_ALU, 4'd0, 1'b0, 1'b0);
    m_cnt = m_cnt + 2'd1;
    cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag, input logic mr, input logic ec);
    drive(1'b0, 8'd0, 1'b0, K_ALU, 4'd0, mr, ec);
    if (ec) m_err = 1'b0;
    cycle(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    m_a = 4'd0; m_b = 4'd0; m_w = 4'd0; m_op = 4'd0;
    m_wbs = 2'd0; m_cnt = 2'd0; m_tgt = 12'd0; m_err = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 8'd0, 1'b0, K_ALU, 4'd0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    compare("reset_state", mexp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b1;

    // ALU: PUT 3,1,2 then op 0x4
    put("alu_put0", 8'd3);
    put("alu_put1", 8'd1);
    put("alu_put2", 8'd2);
    drive(1'b0, 8'd0, 1'b1, K_ALU, 4'd4, 1'b0, 1'b0);
    m_a = 4'd1; m_b = 4'd2; m_w = 4'd3; m_op = 4'd4; m_wbs = 2'd0; m_cnt = 2'd0;
    cycle("alu_exec", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("alu_done", 1'b0, 1'b0);

    // JUMP: PUT 0x05, 0xA7 -> target 0x5A7
    put("jmp_put0", 8'h05);
    put("jmp_put1", 8'hA7);
    drive(1'b0, 8'd0, 1'b1, K_JUMP, 4'd0, 1'b0, 1'b0);
    m_a = 4'h7; m_b = 4'd0; m_w = 4'd5; m_op = 4'd0; m_tgt = 12'h5A7; m_cnt = 2'd0;
    cycle("jmp_exec", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle("jmp_done", 1'b0, 1'b0);

    // LOAD: mem_ready three cycles late -> four read-strobe cycles, then WB
    put("ld_put0", 8'd6);
    put("ld_put1", 8'd2);
    drive(1'b0, 8'd0, 1'b1, K_LOAD, 4'd0, 1'b0, 1'b0);
    m_a = 4'd2; m_b = 4'd0; m_w = 4'd6; m_op = 4'd0; m_cnt = 2'd0;
    cycle("ld_exec", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'd0, 1'b0, K_ALU, 4'd0, 1'b0, 1'b0);
      cycle("ld_wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    drive(1'b0, 8'd0, 1'b0, K_ALU, 4'd0, 1'b1, 1'b0);
    m_wbs = 2'd1;
    cycle("ld_wb", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("ld_done", 1'b0, 1'b0);

    // STORE with mem_ready already high: minimum latency
    put("st_put0", 8'd9);
    put("st_put1", 8'd4);
    drive(1'b0, 8'd0, 1'b1, K_STORE, 4'd0, 1'b1, 1'b0);
    m_a = 4'd4; m_b = 4'd0; m_w = 4'd9; m_cnt = 2'd0;
    cycle("st_exec", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle("st_done", 1'b1, 1'b0);

    // protocol errors
    put("e_put", 8'h0B);
    drive(1'b0, 8'd0, 1'b1, K_ALU, 4'd7, 1'b0, 1'b0);
    m_err = 1'b1; m_cnt = 2'd0;
    cycle("e_short_op", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("e_clr1", 1'b0, 1'b1);
    put("e_fill0", 8'd1);
    put("e_fill1", 8'd2);
    put("e_fill2", 8'd3);
    drive(1'b1, 8'd4, 1'b0, K_ALU, 4'd0, 1'b0, 1'b0);
    m_err = 1'b1;
    cycle("e_overflow", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("e_clr2", 1'b0, 1'b1);
    drive(1'b1, 8'd5, 1'b0, K_ALU, 4'd0, 1'b0, 1'b1);
    m_err = 1'b1;
    cycle("e_set_wins", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("e_clr3", 1'b0, 1'b1);
    drive(1'b1, 8'h0F, 1'b1, K_ALU, 4'd9, 1'b0, 1'b0);
    m_a = 4'd2; m_b = 4'd3; m_w = 4'd1; m_op = 4'd9; m_wbs = 2'd0; m_cnt = 2'd0; m_err = 1'b1;
    cycle("e_op_put", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("e_err_sticky", 1'b0, 1'b0);
    idle("e_clr4", 1'b0, 1'b1);
    put("e_put2", 8'd5);
    drive(1'b1, 8'd6, 1'b1, K_LOAD, 4'd0, 1'b0, 1'b0);
    m_err = 1'b1; m_cnt = 2'd0;
    cycle("e_short_both", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("e_clr5", 1'b0, 1'b1);

    // reset asserted mid-operation
    put("rs_put0", 8'd7);
    put("rs_put1", 8'd8);
    drive(1'b0, 8'd0, 1'b1, K_LOAD, 4'd0, 1'b0, 1'b0);
    m_a = 4'd8; m_b = 4'd0; m_w = 4'd7; m_op = 4'd0; m_cnt = 2'd0;
    cycle("rs_exec", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'd1, 1'b0, K_ALU, 4'd0, 1'b0, 1'b0);
    m_err = 1'b1;
    cycle("rs_busy_put", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 8'd0, 1'b0, K_ALU, 4'd0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    model_reset();
    compare("rs_async", mexp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b1;
    idle("rs_release", 1'b1, 1'b0);
    put("rs_collect", 8'd3);
    idle("rs_collect_idle", 1'b0, 1'b0);

    // memory never ready
    put("to_put1", 8'd2);
    drive(1'b0, 8'd0, 1'b1, K_LOAD, 4'd0, 1'b0, 1'b0);
    m_a = 4'd2; m_b = 4'd0; m_w = 4'd3; m_op = 4'd0; m_cnt = 2'd0;
    cycle("to_exec", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef ISSUE_MEM_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, 8'd0, 1'b0, K_ALU, 4'd0, 1'b0, 1'b0);
      cycle("to_wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    drive(1'b0, 8'd0, 1'b0, K_ALU, 4'd0, 1'b0, 1'b0);
    m_err = 1'b1;
    cycle("to_drop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle("to_no_wb", 1'b1, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 8'd0, 1'b0, K_ALU, 4'd0, 1'b0, 1'b0);
      cycle("to_wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    drive(1'b0, 8'd0, 1'b0, K_ALU, 4'd0, 1'b1, 1'b0);
    m_wbs = 2'd1;
    cycle("to_late_wb", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("to_done", 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
